// File: rtl/psum_drain.sv
// PSUM SRAM read-out engine: streams a contiguous row range over valid/ready.
// A 2-entry skid buffer absorbs the one-cycle SRAM read latency under backpressure.
module psum_drain #(
   parameter int unsigned PsumBw = 16,
   parameter int unsigned Col    = 8,
   parameter int unsigned AddrBw = 11
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [AddrBw-1:0]      base_addr,
   input  logic [AddrBw:0]        num_rows,
   output logic                   busy,
   output logic                   done,
   output logic                   sram_cen,
   output logic                   sram_wen,
   output logic [AddrBw-1:0]      sram_addr,
   input  logic [Col*PsumBw-1:0]  sram_q,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [Col*PsumBw-1:0]  out_data,
   output logic                   out_last
);

   localparam int unsigned RowW = Col * PsumBw;
   localparam logic [AddrBw:0] CntOne = {{AddrBw{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain
   } state_e;

   state_e              state_q, state_d;
   logic [AddrBw-1:0]   base_q, base_d;
   logic [AddrBw:0]     num_q, num_d;
   logic [AddrBw:0]     issued_q, issued_d;
   logic [AddrBw:0]     accepted_q, accepted_d;
   logic                inflight_q, inflight_d;
   logic                done_q, done_d;
   logic                zdone_q, zdone_d;

   logic [RowW-1:0]     buf_q [2];
   logic [RowW-1:0]     buf_d [2];
   logic                wr_ptr_q, wr_ptr_d;
   logic                rd_ptr_q, rd_ptr_d;
   logic [1:0]          fill_q, fill_d;

   logic                start_ok;
   logic                issue_room;
   logic                issue;
   logic                push;
   logic                pop;
   logic                head_last;

   // A start landing on a done pulse (either flavour) is dropped.
   assign start_ok  = start & (state_q == StIdle) & ~done_q & ~zdone_q;

   assign out_valid = (fill_q != 2'd0);
   assign pop       = out_valid & out_ready;
   assign push      = inflight_q;
   assign head_last = (accepted_q == (num_q - CntOne));

   // Issue only if the returning row still fits after this cycle's pop.
   assign issue_room = ({1'b0, fill_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
   assign issue      = (state_q == StRun) & (issued_q != num_q) & issue_room;

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      num_d      = num_q;
      issued_d   = issued_q;
      accepted_d = accepted_q + {{AddrBw{1'b0}}, pop};
      inflight_d = issue;
      done_d     = 1'b0;
      zdone_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start_ok) begin
               base_d     = base_addr;
               num_d      = num_rows;
               issued_d   = '0;
               accepted_d = '0;
               if (num_rows == '0) begin
                  zdone_d = 1'b1;
               end else begin
                  state_d = StRun;
               end
            end
         end
         StRun: begin
            if (issue) begin
               issued_d = issued_q + CntOne;
               if ((issued_q + CntOne) == num_q) begin
                  state_d = StDrain;
               end
            end
         end
         StDrain: begin
            if (pop && head_last) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Skid buffer: sram_q is captured the cycle after each issue.
   always_comb begin
      buf_d    = buf_q;
      wr_ptr_d = wr_ptr_q ^ push;
      rd_ptr_d = rd_ptr_q ^ pop;
      fill_d   = fill_q + {1'b0, push} - {1'b0, pop};
      if (push) begin
         buf_d[wr_ptr_q] = sram_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         base_q     <= '0;
         num_q      <= '0;
         issued_q   <= '0;
         accepted_q <= '0;
         inflight_q <= 1'b0;
         done_q     <= 1'b0;
         zdone_q    <= 1'b0;
         buf_q[0]   <= '0;
         buf_q[1]   <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         fill_q     <= 2'd0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         num_q      <= num_d;
         issued_q   <= issued_d;
         accepted_q <= accepted_d;
         inflight_q <= inflight_d;
         done_q     <= done_d;
         zdone_q    <= zdone_d;
         buf_q      <= buf_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fill_q     <= fill_d;
      end
   end

   // A zero-length request pulses done without ever reporting busy.
   assign busy      = (state_q != StIdle) | done_q;
   assign done      = done_q | zdone_q;
   assign sram_cen  = ~issue;
   assign sram_wen  = 1'b1;
   assign sram_addr = issue ? (base_q + issued_q[AddrBw-1:0]) : '0;
   assign out_data  = out_valid ? buf_q[rd_ptr_q] : '0;
   assign out_last  = out_valid & head_last;

endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain: SRAM model, event logs and assertion-based checks.
module tb_psum_drain;

   localparam int unsigned PsumBw = 16;
   localparam int unsigned Col    = 8;
   localparam int unsigned AddrBw = 11;
   localparam int unsigned RowW   = PsumBw * Col;
   localparam logic [31:0] AllOnes = 32'hFFFF_FFFF;
   localparam logic [31:0] BpPat   = 32'b1001_0110_1100_1011_0010_1101_0011_1001;

   logic                clk = 1'b0;
   logic                reset_n;
   logic                start;
   logic [AddrBw-1:0]   base_addr;
   logic [AddrBw:0]     num_rows;
   logic                busy;
   logic                done;
   logic                sram_cen;
   logic                sram_wen;
   logic [AddrBw-1:0]   sram_addr;
   logic [RowW-1:0]     sram_q = '0;
   logic                out_valid;
   logic                out_ready;
   logic [RowW-1:0]     out_data;
   logic                out_last;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   psum_drain #(
      .PsumBw (PsumBw),
      .Col    (Col),
      .AddrBw (AddrBw)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .base_addr (base_addr),
      .num_rows  (num_rows),
      .busy      (busy),
      .done      (done),
      .sram_cen  (sram_cen),
      .sram_wen  (sram_wen),
      .sram_addr (sram_addr),
      .sram_q    (sram_q),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [RowW-1:0] pattern(input logic [AddrBw-1:0] a);
      logic [RowW-1:0] r;
      r = '0;
      for (int i = 0; i < Col; i++) begin
         r[i*PsumBw +: PsumBw] = {3'(i) ^ 3'b101, 2'b10, a};
      end
      return r;
   endfunction

   // One-cycle read latency SRAM preloaded with pattern().
   always @(posedge clk) begin
      if (sram_cen === 1'b0) sram_q <= pattern(sram_addr);
   end

   task automatic chk(input string tag, input logic [RowW-1:0] got, input logic [RowW-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [AddrBw-1:0] rd_addr_q [$];
   int                rd_cyc_q  [$];
   logic [RowW-1:0]   acc_data_q[$];
   logic              acc_last_q[$];
   int                acc_cyc_q [$];
   int                done_cyc_q[$];
   int                busy_cyc_q[$];
   int                outstanding = 0;
   logic              prev_stall  = 1'b0;
   logic [RowW-1:0]   prev_data   = '0;
   logic              prev_last   = 1'b0;

   // Observed port activity, sampled mid-cycle.
   always @(negedge clk) begin
      if (reset_n !== 1'b1) begin
         outstanding = 0;
         prev_stall  = 1'b0;
      end else begin
         chk("wen_high", sram_wen, 1);
         if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, prev_data);
            chk("stall_last", out_last, prev_last);
         end
         if (sram_cen === 1'b0) begin
            rd_addr_q.push_back(sram_addr);
            rd_cyc_q.push_back(cyc);
            outstanding++;
         end
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            acc_data_q.push_back(out_data);
            acc_last_q.push_back(out_last);
            acc_cyc_q.push_back(cyc);
            outstanding--;
         end
         chk("outstanding_le2", outstanding <= 2, 1);
         if (done === 1'b1) done_cyc_q.push_back(cyc);
         if (busy === 1'b1) busy_cyc_q.push_back(cyc);
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
      end
   end

   task automatic clear_logs();
      rd_addr_q.delete();
      rd_cyc_q.delete();
      acc_data_q.delete();
      acc_last_q.delete();
      acc_cyc_q.delete();
      done_cyc_q.delete();
      busy_cyc_q.delete();
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_cen"}, sram_cen, 1);
      chk({tag, "_wen"}, sram_wen, 1);
      chk({tag, "_addr"}, sram_addr, 0);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_data"}, out_data, 0);
      chk({tag, "_last"}, out_last, 0);
   endtask

   // Start pulse in cycle kc; inputs scrambled afterwards to prove sampling.
   task automatic kick(input logic [AddrBw-1:0] b, input logic [AddrBw:0] n, output int kc);
      @(posedge clk); #1;
      kc        = cyc;
      start     = 1'b1;
      base_addr = b;
      num_rows  = n;
      @(posedge clk); #1;
      start     = 1'b0;
      base_addr = ~b;
      num_rows  = '0;
   endtask

   task automatic run_until_done(input logic [31:0] pat, input int budget, input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         out_ready = pat[i % 32];
         @(negedge clk);
         seen = (done === 1'b1);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      chk({tag, "_done_seen"}, seen, 1);
   endtask

   task automatic check_drain(input string tag, input logic [AddrBw-1:0] b, input int n,
                              input int kc, input bit exact, input int ndone);
      logic [AddrBw-1:0] a;
      chk({tag, "_nreads"}, rd_addr_q.size(), n);
      chk({tag, "_naccepts"}, acc_data_q.size(), n);
      for (int j = 0; j < n; j++) begin
         a = b + AddrBw'(j);
         if (j < rd_addr_q.size()) begin
            chk($sformatf("%s_addr%0d", tag, j), rd_addr_q[j], a);
            if (exact) chk($sformatf("%s_rdcyc%0d", tag, j), rd_cyc_q[j], kc + 1 + j);
         end
         if (j < acc_data_q.size()) begin
            chk($sformatf("%s_data%0d", tag, j), acc_data_q[j], pattern(a));
            chk($sformatf("%s_last%0d", tag, j), acc_last_q[j], (j == n - 1) ? 1 : 0);
            if (exact) chk($sformatf("%s_acccyc%0d", tag, j), acc_cyc_q[j], kc + 3 + j);
         end
      end
      chk({tag, "_ndone"}, done_cyc_q.size(), ndone);
      if (exact && done_cyc_q.size() > 0) chk({tag, "_donecyc"}, done_cyc_q[$], kc + n + 3);
   endtask

   initial begin
      int kc;
      reset_n   = 1'b0;
      start     = 1'b0;
      base_addr = '0;
      num_rows  = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      reset_n = 1'b1;

      // Basic drain with full-rate consumer.
      clear_logs();
      kick(11'h010, 4, kc);
      run_until_done(AllOnes, 50, "basic");
      check_drain("basic", 11'h010, 4, kc, 1'b1, 1);
      chk("basic_nbusy", busy_cyc_q.size(), 7);
      if (busy_cyc_q.size() > 0) begin
         chk("basic_busy_first", busy_cyc_q[0], kc + 1);
         chk("basic_busy_last", busy_cyc_q[$], kc + 7);
      end
      check_idle_outputs("basic_after");

      // Backpressure.
      clear_logs();
      kick(11'h100, 8, kc);
      run_until_done(BpPat, 200, "bp");
      check_drain("bp", 11'h100, 8, kc, 1'b0, 1);

      // Address wrap-around.
      clear_logs();
      kick(11'h7FE, 4, kc);
      run_until_done(AllOnes, 50, "wrap");
      check_drain("wrap", 11'h7FE, 4, kc, 1'b1, 1);

      // Zero length, then a start in the done cycle (ignored) and one after (accepted).
      clear_logs();
      @(posedge clk); #1;
      kc        = cyc;
      start     = 1'b1;
      base_addr = 11'h020;
      num_rows  = 0;
      @(posedge clk); #1;
      base_addr = 11'h040;
      num_rows  = 2;
      @(posedge clk); #1;
      base_addr = 11'h030;
      num_rows  = 2;
      @(posedge clk); #1;
      start     = 1'b0;
      base_addr = '0;
      num_rows  = '0;
      run_until_done(AllOnes, 50, "zero");
      check_drain("zero_restart", 11'h030, 2, kc + 2, 1'b1, 2);
      if (done_cyc_q.size() > 0) chk("zero_done_cyc", done_cyc_q[0], kc + 1);
      chk("zero_nbusy", busy_cyc_q.size(), 5);
      if (busy_cyc_q.size() > 0) chk("zero_busy_first", busy_cyc_q[0], kc + 3);

      // Reset mid-drain aborts without done.
      clear_logs();
      kick(11'h200, 16, kc);
      for (int i = 0; i < 60 && acc_data_q.size() < 5; i++) @(negedge clk);
      chk("rst_five_accepted", acc_data_q.size() >= 5, 1);
      for (int j = 0; j < 5 && j < acc_data_q.size(); j++) begin
         chk($sformatf("rst_data%0d", j), acc_data_q[j], pattern(11'h200 + AddrBw'(j)));
      end
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      check_idle_outputs("rst_mid");
      repeat (3) @(posedge clk);
      #1;
      chk("rst_no_done", done_cyc_q.size(), 0);
      check_idle_outputs("rst_hold");
      reset_n = 1'b1;
      clear_logs();
      kick(11'h300, 2, kc);
      run_until_done(AllOnes, 50, "rst_redo");
      check_drain("rst_redo", 11'h300, 2, kc, 1'b1, 1);

      // Start while busy is ignored.
      clear_logs();
      kick(11'h400, 6, kc);
      @(posedge clk); #1;
      start     = 1'b1;
      base_addr = 11'h500;
      num_rows  = 3;
      @(posedge clk); #1;
      start     = 1'b0;
      num_rows  = '0;
      run_until_done(AllOnes, 50, "busy_start");
      repeat (4) @(posedge clk);
      #1;
      check_drain("busy_start", 11'h400, 6, kc, 1'b1, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/psum_drain.md
# psum_drain

Read-out engine for the PSUM SRAM: after the SFP has finished its accumulate/ReLU write-backs, this block reads a contiguous range of PSUM rows and streams them off-chip or to the checker over a valid/ready interface. It owns the SRAM read port during a drain and absorbs the SRAM's one-cycle read latency with a 2-entry skid buffer, so it sustains one row per cycle and still honours backpressure.

## Interface
- psum_bw, 16, width of one partial sum
- col, 8, partial sums per SRAM row (row width = col*psum_bw)
- addr_bw, 11, PSUM SRAM address width
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a drain; ignored while busy
- base_addr  in  addr_bw  first row address, sampled with start
- num_rows  in  addr_bw+1  rows to read, sampled with start; 0 is legal
- busy  out  1  drain in progress
- done  out  1  one-cycle pulse at drain completion
- sram_cen  out  1  SRAM chip enable, active low
- sram_wen  out  1  SRAM write enable, active low; constant 1
- sram_addr  out  addr_bw  SRAM read address
- sram_q  in  col*psum_bw  SRAM read data, valid the cycle after sram_cen low
- out_valid  out  1  out_data/out_last valid
- out_ready  in  1  consumer accepts when high with out_valid
- out_data  out  col*psum_bw  one PSUM row, passed unmodified
- out_last  out  1  high with the final row of the drain

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: start=1 latches base_addr and num_rows, clears the issue and accept counters, and moves to RUN. If num_rows=0, it instead pulses done in the next cycle, issues no reads and stays in IDLE.
- RUN: each cycle a read is issued (sram_cen=0, sram_addr=base+issued) when fill + inflight - pop < 2.
  - fill is the buffer occupancy.
  - inflight is a registered flag meaning a read was issued last cycle.
  - pop is out_valid & out_ready.
  - sram_cen is combinational from registered state and counters.
  - sram_addr wraps modulo 2^addr_bw.
  - When issued reaches num_rows, go to DRAIN.
- The buffer captures sram_q at the end of the cycle after each issue and holds it until popped. It is a 2-entry FIFO and outputs in order.
- DRAIN: no reads. When the row with out_last is accepted, done pulses in the next cycle and the state returns to IDLE.
- out_last=1 exactly when the head entry is row index num_rows-1.
- busy=1 from the cycle after start through the cycle done is high.
- The buffer must never overflow. Any write into a full buffer is a design error, and the bench asserts against it.
- sram_wen is tied to 1. No data transformation is applied; sign and width are preserved.

## Timing
- Reset values: busy=0, done=0, sram_cen=1, sram_wen=1, sram_addr=0, out_valid=0, out_data=0, out_last=0. Buffer and counters are cleared.
- Reset asserted mid-drain aborts immediately, with no done pulse. Rows not yet accepted are discarded.
- Latency: start is sampled at edge k.
  - First sram_cen=0 occurs in cycle k+1.
  - The data returns in cycle k+2.
  - The first out_valid is in cycle k+3.
- Throughput: with out_ready held high, one row per cycle. N rows are accepted in cycles k+3 through k+N+2, and done is high in cycle k+N+3.
- With out_ready low, at most 2 reads are outstanding or buffered. Issue resumes in the same cycle the consumer pops.
- out_valid/out_data/out_last are held stable while out_valid=1 and out_ready=0.
- start while busy, or in the done cycle, is ignored. A start in the cycle after done is accepted.

## Test plan
- Basic drain: base_addr=0x010, num_rows=4, out_ready=1, SRAM rows preloaded with distinct patterns.
  - Required: reads of 0x010..0x013 in cycles k+1..k+4.
  - Required: out_valid in k+3..k+6 with matching data, out_last in k+6, done in k+7.
- Backpressure: num_rows=8, out_ready toggling 1,0,0,1,... at random.
  - Required: all 8 rows appear in order, none dropped or duplicated, data stable while stalled.
  - Required: no buffer overflow and never more than 2 rows outstanding.
- Wrap-around: base_addr=0x7FE, num_rows=4.
  - Required: addresses 0x7FE, 0x7FF, 0x000, 0x001; out_last on the fourth row.
- Zero length: start with num_rows=0.
  - Required: sram_cen stays 1, out_valid stays 0, done pulses in cycle k+1, busy stays 0.
- Reset mid-drain: num_rows=16, assert reset_n=0 after 5 rows are accepted.
  - Required: all outputs immediately at reset values, no done pulse.
  - Required: a new start with num_rows=2 after release drains correctly.
- Start while busy: a second start with different base_addr in the middle of a 6-row drain.
  - Required: the second start is ignored, the original 6 rows are delivered, and there is exactly one done pulse.
